// File: rtl/sram_responder.sv
// On-chip stand-in for the external 16-bit SRAM: active-low pin protocol, byte-lane writes,
// registered reads with a drive enable, clear-after-reset sweep and a side preload port.
module sram_responder #(
  parameter int ADDR_W         = 10,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CE,
  input  logic              WE,
  input  logic              OE,
  input  logic              UB,
  input  logic              LB,
  input  logic [19:0]       ADDR,
  input  logic [15:0]       Data_In,
  output logic [15:0]       Data_Out,
  output logic              Data_OE,
  input  logic              Init_Wr,
  input  logic [ADDR_W-1:0] Init_Addr,
  input  logic [15:0]       Init_Data,
  output logic              Init_Ack,
  output logic              Busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [15:0]       mem_q [DEPTH];

  logic [READ_LAT:1]       vld_pipe_q;
  logic [READ_LAT:1][15:0] dat_pipe_q;
  logic                    ack_q;

  logic [ADDR_W-1:0] waddr;
  logic              idle, bus_wr, bus_rd, init_wr;
  logic [15:0]       rd_word;
  logic              unused_addr_hi;

  // Upper address bits are deliberately not decoded, so the array aliases across them.
  assign waddr          = ADDR[ADDR_W-1:0];
  assign unused_addr_hi = ^ADDR[19:ADDR_W];

  assign idle    = (state_q == ST_IDLE);
  assign bus_wr  = idle & ~CE & ~WE;
  assign bus_rd  = idle & ~CE & WE & ~OE;
  assign init_wr = idle & CE & Init_Wr;

  assign rd_word = {UB ? 8'h00 : mem_q[waddr][15:8],
                    LB ? 8'h00 : mem_q[waddr][7:0]};

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Bus beats preload when both request the same edge; the preloader retries.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (bus_wr) begin
        if (!UB) mem_q[waddr][15:8] <= Data_In[15:8];
        if (!LB) mem_q[waddr][7:0]  <= Data_In[7:0];
      end else if (init_wr) begin
        mem_q[Init_Addr] <= Init_Data;
      end
    end
  end

  // Data stages load only behind a valid beat, so the output word holds when idle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      vld_pipe_q[1] <= bus_rd;
      if (bus_rd) dat_pipe_q[1] <= rd_word;
      for (int i = 2; i <= READ_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        if (vld_pipe_q[i-1]) dat_pipe_q[i] <= dat_pipe_q[i-1];
      end
      ack_q <= init_wr;
    end
  end

  assign Data_OE  = vld_pipe_q[READ_LAT];
  assign Data_Out = dat_pipe_q[READ_LAT];
  assign Init_Ack = ack_q;
  assign Busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: a cycle-level memory model checks every output each
// cycle, and the directed steps pin key results with hand-computed literals.
module tb_sram_responder;
  localparam int AW    = 4;
  localparam int RL    = 2;
  localparam int DEPTH = 16;

  logic          Clk = 1'b0;
  logic          Reset, CE, WE, OE, UB, LB, Init_Wr;
  logic [19:0]   ADDR;
  logic [15:0]   Data_In, Init_Data;
  logic [AW-1:0] Init_Addr;
  logic [15:0]   Data_Out;
  logic          Data_OE, Init_Ack, Busy;

  sram_responder #(.ADDR_W(AW), .READ_LAT(RL), .CLEAR_ON_RESET(1)) dut (
    .Clk(Clk), .Reset(Reset), .CE(CE), .WE(WE), .OE(OE), .UB(UB), .LB(LB),
    .ADDR(ADDR), .Data_In(Data_In), .Data_Out(Data_Out), .Data_OE(Data_OE),
    .Init_Wr(Init_Wr), .Init_Addr(Init_Addr), .Init_Data(Init_Data),
    .Init_Ack(Init_Ack), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: word array, count of remaining clear cycles, queue of due read beats.
  typedef struct { int due; logic [15:0] d; } rd_t;
  logic [15:0] m_mem [DEPTH];
  rd_t         m_q [$];
  int          m_clr  = -1;
  int          cyc    = 0;
  bit          started = 0;
  bit          m_oe = 0, m_ack = 0, m_busy = 0;
  logic [15:0] m_dout = '0;

  always @(posedge Clk) begin
    int a;
    cyc++;
    a = int'(ADDR) % DEPTH;
    if (Reset) begin
      started = 1;
      m_q.delete();
      m_dout = '0;
      m_oe   = 0;
      m_ack  = 0;
      m_clr  = 0;
    end else if (started) begin
      m_ack = 0;
      if (m_clr >= 0) begin
        m_mem[m_clr] = '0;
        m_clr++;
        if (m_clr == DEPTH) m_clr = -1;
      end else if (!CE && !WE) begin
        if (!UB) m_mem[a][15:8] = Data_In[15:8];
        if (!LB) m_mem[a][7:0]  = Data_In[7:0];
      end else if (!CE && !OE) begin
        rd_t r;
        r.due = cyc + RL - 1;
        r.d   = {UB ? 8'h00 : m_mem[a][15:8], LB ? 8'h00 : m_mem[a][7:0]};
        m_q.push_back(r);
      end else if (CE && Init_Wr) begin
        m_mem[Init_Addr] = Init_Data;
        m_ack = 1;
      end
      m_oe = 0;
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        m_oe   = 1;
        m_dout = m_q[0].d;
        void'(m_q.pop_front());
      end
    end
    m_busy = (m_clr >= 0);
  end

  always @(negedge Clk) begin
    if (started) begin
      chk("oe_model",   {31'd0, Data_OE},  {31'd0, m_oe});
      chk("busy_model", {31'd0, Busy},     {31'd0, m_busy});
      chk("ack_model",  {31'd0, Init_Ack}, {31'd0, m_ack});
      chk("dout_model", {16'd0, Data_Out}, {16'd0, m_dout});
    end
  end

  task automatic idle_bus();
    CE = 1; WE = 1; OE = 1; UB = 1; LB = 1; Init_Wr = 0;
  endtask

  task automatic bus_write(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
    CE = 0; WE = 0; OE = 1; UB = ub; LB = lb; ADDR = a; Data_In = d;
    @(posedge Clk); #1;
    idle_bus();
  endtask

  task automatic read_word(input string nm, input logic [19:0] a, input logic ub, input logic lb,
                           input logic [15:0] exp);
    int lat;
    logic [15:0] d;
    CE = 0; WE = 1; OE = 0; UB = ub; LB = lb; ADDR = a;
    @(posedge Clk); #1;
    idle_bus();
    lat = 0;
    d   = 'x;
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clk);
      if (Data_OE) begin
        lat = i;
        d   = Data_Out;
        break;
      end
    end
    chk({nm, "_lat"}, lat, RL);
    chk(nm, {16'd0, d}, {16'd0, exp});
  endtask

  task automatic count_busy(input string nm, input int start);
    int cnt;
    cnt = start;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Busy) cnt++;
      else break;
    end
    chk(nm, cnt, DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1; idle_bus();
    ADDR = '0; Data_In = '0; Init_Addr = '0; Init_Data = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 0;
    count_busy("clear_cycles", 0);

    read_word("rd_cleared", 20'h9, 0, 0, 16'h0000);

    bus_write(20'h3, 16'hBEEF, 0, 0);
    read_word("rd_beef", 20'h3, 0, 0, 16'hBEEF);

    bus_write(20'h5, 16'h1234, 0, 0);
    bus_write(20'h5, 16'hAAAA, 1, 0);
    read_word("rd_12aa", 20'h5, 0, 0, 16'h12AA);
    read_word("rd_1200", 20'h5, 0, 1, 16'h1200);

    // Preload colliding with a bus cycle is refused.
    CE = 0; WE = 1; OE = 1; Init_Wr = 1; Init_Addr = 4'h7; Init_Data = 16'h00FF;
    @(posedge Clk); #1; idle_bus();
    @(negedge Clk); chk("ack_blocked", {31'd0, Init_Ack}, 32'd0);
    read_word("rd_unchanged", 20'h7, 0, 0, 16'h0000);
    Init_Wr = 1;
    @(posedge Clk); #1; idle_bus();
    @(negedge Clk); chk("ack_pulse", {31'd0, Init_Ack}, 32'd1);
    @(negedge Clk); chk("ack_single", {31'd0, Init_Ack}, 32'd0);
    read_word("rd_preload", 20'h7, 0, 0, 16'h00FF);

    bus_write(20'h2, 16'hCAFE, 0, 0);
    read_word("rd_alias", 20'h2 + DEPTH, 0, 0, 16'hCAFE);
    read_word("rd_alias_hi", 20'hF0002, 0, 0, 16'hCAFE);

    // WE and OE both low: write wins, no read beat.
    CE = 0; WE = 0; OE = 0; UB = 0; LB = 0; ADDR = 20'h4; Data_In = 16'h5555;
    @(posedge Clk); #1; idle_bus();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); chk("oe_on_write", {31'd0, Data_OE}, 32'd0);
    end
    read_word("rd_5555", 20'h4, 0, 0, 16'h5555);

    bus_write(20'h6, 16'h7777, 0, 0);
    read_word("rd_after_wr", 20'h6, 0, 0, 16'h7777);

    // Read stream interrupted by reset.
    CE = 0; WE = 1; OE = 0; UB = 0; LB = 0; ADDR = 20'h3;
    @(posedge Clk); #1; ADDR = 20'h5;
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("stream0_oe", {31'd0, Data_OE}, 32'd1);
    chk("stream0", {16'd0, Data_Out}, 32'h0000BEEF);
    ADDR = 20'h2;
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("stream1_oe", {31'd0, Data_OE}, 32'd1);
    chk("stream1", {16'd0, Data_Out}, 32'h000012AA);
    Reset = 1;
    @(posedge Clk); #1;
    Reset = 0; idle_bus();
    @(negedge Clk);
    chk("rst_oe", {31'd0, Data_OE}, 32'd0);
    chk("rst_dout", {16'd0, Data_Out}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd1);
    count_busy("reclear_cycles", 1);
    read_word("rd_recleared", 20'h3, 0, 0, 16'h0000);

    repeat (3) @(posedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
